// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and FSM state encoding for the data-memory responder.
`default_nettype none

package dmem_pkg;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// dmem_array: 2**AW x DW storage, one synchronous write port, one asynchronous read port.
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// data_mem_responder: core-facing data memory with post-reset clear sweep,
// bulk-load port and single-write-port arbitration.
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_ready,
  output logic          collision
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          collision_q, collision_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          core_wr;
  logic          core_rd;
  logic          drop;

  assign core_wr = ~CEN & ~WEN;
  assign core_rd = ~CEN & WEN & ~OEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collision_q <= collision_d;
    end
  end

  // The array has one write port: sweep and load writes always own it,
  // and a core write that coincides with them is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = A;
    wdata   = D;
    drop    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        cnt_d = cnt_q + 1'b1;
        drop  = core_wr;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        we = core_wr;
        if (ld_start) begin
          cnt_d   = ld_base;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          we    = 1'b1;
          waddr = cnt_q;
          wdata = ld_data;
          cnt_d = cnt_q + 1'b1;
          drop  = core_wr;
          if (ld_last) begin
            state_d = ST_IDLE;
          end
        end else begin
          we = core_wr;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
    collision_d = collision_q | drop;
  end

  dmem_array #(
    .AW(AW),
    .DW(DW)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(A),
    .rdata(rdata)
  );

  assign Q         = (core_rd && state_q != ST_CLEAR) ? rdata : '0;
  assign ld_ready  = (state_q == ST_LOAD);
  assign mem_ready = (state_q != ST_CLEAR);
  assign collision = collision_q;

endmodule

`default_nettype wire
